// File: rtl/tt3_sweep_capture.sv
// Purpose : exhaustively drives {in1,in2,in3} through 000..111, holds each
//           combination SETTLE cycles, samples the block output and builds an
//           8-row truth table, then checks it against EXPECTED.
// Latency : done pulses 8*SETTLE cycles after the start edge; results are
//           registered.
// Backpressure: none; start is taken only in IDLE (no queuing), abort cancels.
// Ports:
//   clk, rst          - clock (rising edge), async active-high reset
//   start, abort      - begin a sweep (IDLE only) / cancel a sweep in progress
//   sample_in         - output of the logic block being swept
//   in1, in2, in3     - registered drive combination (in1 = MSB)
//   busy, done        - sweep in progress / one-cycle completion pulse
//   table_out         - captured table, bit k = sample for combination k
//   match, mismatch   - comparison with EXPECTED, valid from done onward
module tt3_sweep_capture #(
  parameter int unsigned SETTLE   = 4,
  parameter logic [7:0]  EXPECTED = 8'hC4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sample_in,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic [7:0] mismatch
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

  state_t     state;
  logic [2:0] combo;
  logic [7:0] settle_cnt;
  logic [7:0] final_table;

  // Table including the capture happening on this edge, so match/mismatch
  // can be registered together with the last row.
  always_comb begin
    final_table        = table_out;
    final_table[combo] = sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      combo      <= 3'd0;
      settle_cnt <= 8'd0;
      in1        <= 1'b0;
      in2        <= 1'b0;
      in3        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= 8'd0;
      match      <= 1'b0;
      mismatch   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state          <= SWEEP;
            combo          <= 3'd0;
            {in1, in2, in3} <= 3'd0;
            settle_cnt     <= RELOAD;
            table_out      <= 8'd0;
            match          <= 1'b0;
            mismatch       <= 8'd0;
            busy           <= 1'b1;
          end
        end

        SWEEP: begin
          if (abort) begin
            // Abort wins over a capture on the same edge; partial rows stay.
            state           <= IDLE;
            combo           <= 3'd0;
            {in1, in2, in3} <= 3'd0;
            busy            <= 1'b0;
            match           <= 1'b0;
            mismatch        <= 8'd0;
          end else if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end else begin
            table_out <= final_table;
            if (combo != 3'd7) begin
              combo           <= combo + 3'd1;
              {in1, in2, in3} <= combo + 3'd1;
              settle_cnt      <= RELOAD;
            end else begin
              state           <= DONE;
              combo           <= 3'd0;
              {in1, in2, in3} <= 3'd0;
              busy            <= 1'b0;
              done            <= 1'b1;
              match           <= (final_table == EXPECTED);
              mismatch        <= final_table ^ EXPECTED;
            end
          end
        end

        DONE: begin
          // Single-cycle state; start is deliberately not looked at here.
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt3_sweep_capture.sv
module tb_tt3_sweep_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // SETTLE=4 instance
  logic       start4 = 1'b0, abort4 = 1'b0, smp4;
  logic       in1_4, in2_4, in3_4, busy4, done4, match4;
  logic [7:0] table4, mm4;
  logic [2:0] drv4;
  int         mode4 = 0;

  // SETTLE=1 instance
  logic       start1 = 1'b0, abort1 = 1'b0, smp1;
  logic       in1_1, in2_1, in3_1, busy1, done1, match1;
  logic [7:0] table1, mm1;

  tt3_sweep_capture #(.SETTLE(4), .EXPECTED(8'hC4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .sample_in(smp4),
    .in1(in1_4), .in2(in2_4), .in3(in3_4), .busy(busy4), .done(done4),
    .table_out(table4), .match(match4), .mismatch(mm4)
  );

  tt3_sweep_capture #(.SETTLE(1), .EXPECTED(8'hC4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .sample_in(smp1),
    .in1(in1_1), .in2(in2_1), .in3(in3_1), .busy(busy1), .done(done1),
    .table_out(table1), .match(match1), .mismatch(mm1)
  );

  // Models of the logic block under sweep
  logic [7:0] tt_model;
  assign drv4 = {in1_4, in2_4, in3_4};
  always_comb begin
    case (mode4)
      0:       tt_model = 8'hC4;
      1:       tt_model = 8'hCC;   // row 3 forced to 1
      default: tt_model = 8'hFF;   // constant 1
    endcase
    smp4 = tt_model[drv4];
  end
  assign smp1 = in1_1;             // table F0

  // Scoreboard
  typedef struct {
    logic [7:0] tbl;
    logic       mt;
    logic [7:0] mm;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] tbl, input int lat);
    exp_t e;
    e.tbl = tbl;
    e.mt  = (tbl == 8'hC4);
    e.mm  = tbl ^ 8'hC4;
    e.lat = lat;
    sb.push_back(e);
  endtask

  function automatic logic [2:0] cur_drv(input bit s1);
    return s1 ? {in1_1, in2_1, in3_1} : {in1_4, in2_4, in3_4};
  endfunction
  function automatic logic cur_done(input bit s1);
    return s1 ? done1 : done4;
  endfunction
  function automatic logic cur_busy(input bit s1);
    return s1 ? busy1 : busy4;
  endfunction

  // Called just after edge E0+n0; follows the sweep to done and scores it.
  task automatic finish_sweep(input bit s1, input int settle, input int n0, input bit post);
    int   n;
    bit   seen;
    exp_t e;
    n    = n0;
    seen = 1'b0;
    while (!seen && n < 8 * settle + 8) begin
      step();
      n++;
      if (cur_done(s1)) seen = 1'b1;
      else begin
        chk("busy_in_sweep", cur_busy(s1), 1);
        chk("drive_step", cur_drv(s1), n / settle);
      end
    end
    chk("done_seen", seen, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("done_latency", n, e.lat);
      chk("table_out", s1 ? table1 : table4, e.tbl);
      chk("match", s1 ? match1 : match4, e.mt);
      chk("mismatch", s1 ? mm1 : mm4, e.mm);
    end
    chk("busy_at_done", cur_busy(s1), 0);
    chk("drive_at_done", cur_drv(s1), 0);
    if (post) begin
      step();
      chk("done_one_cycle", cur_done(s1), 0);
      chk("busy_after_done", cur_busy(s1), 0);
    end
  endtask

  task automatic begin_sweep4(input int mode, input logic [7:0] tbl, input bit score);
    mode4 = mode;
    if (score) push_exp(tbl, 8 * 4);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("busy_at_start", busy4, 1);
    chk("drive_at_start", drv4, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_table", table4, 0);
    chk("rst_match", match4, 0);
    chk("rst_mismatch", mm4, 0);
    chk("rst_drive", drv4, 0);
    rst = 1'b0;
    step();

    // 1: matching block, SETTLE=4
    begin_sweep4(0, 8'hC4, 1);
    finish_sweep(0, 4, 0, 1);

    // 2: row 3 forced high
    begin_sweep4(1, 8'hCC, 1);
    finish_sweep(0, 4, 0, 1);

    // 3: SETTLE=1, block returns in1; start on the done cycle is ignored
    push_exp(8'hF0, 8);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("s1_busy_at_start", busy1, 1);
    finish_sweep(1, 1, 0, 0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("s1_start_in_done_ignored", busy1, 0);
    chk("s1_done_cleared", done1, 0);
    push_exp(8'hF0, 8);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("s1_restart_busy", busy1, 1);
    chk("s1_restart_drive", {in1_1, in2_1, in3_1}, 0);
    finish_sweep(1, 1, 0, 1);

    // 4: abort during combo 2 (edge E0+10), constant-1 block
    begin_sweep4(2, 8'h00, 0);
    repeat (9) step();
    chk("abort_pre_drive", drv4, 2);
    abort4 = 1'b1;
    step();
    abort4 = 1'b0;
    chk("abort_busy", busy4, 0);
    chk("abort_drive", drv4, 0);
    chk("abort_done", done4, 0);
    chk("abort_table", table4, 8'h03);
    chk("abort_match", match4, 0);
    chk("abort_mismatch", mm4, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", done4, 0);
      chk("abort_stays_idle", busy4, 0);
    end

    // 5: start+abort together in IDLE, then a re-pulsed start while busy
    start4 = 1'b1;
    abort4 = 1'b1;
    step();
    start4 = 1'b0;
    abort4 = 1'b0;
    chk("start_abort_idle", busy4, 0);
    chk("start_abort_table", table4, 8'h03);
    begin_sweep4(0, 8'hC4, 1);
    repeat (5) step();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("restart_while_busy_drive", drv4, 1);
    finish_sweep(0, 4, 6, 1);

    // 6: async reset at E0+17, no edge needed
    begin_sweep4(0, 8'h00, 0);
    repeat (16) step();
    chk("pre_rst_table", table4, 8'h04);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy4, 0);
    chk("arst_table", table4, 0);
    chk("arst_drive", drv4, 0);
    chk("arst_done", done4, 0);
    chk("arst_match", match4, 0);
    chk("arst_mismatch", mm4, 0);
    step();
    step();
    chk("arst_held_no_done", done4, 0);
    rst = 1'b0;
    step();
    begin_sweep4(0, 8'hC4, 1);
    finish_sweep(0, 4, 0, 1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
